// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO and active-low CTS flow control; 8N1 by default,
// 8E1 when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
   parameter int BAUD_COUNT = 645,
   parameter int FIFO_DEPTH = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic [7:0]                    data_in,
   input  logic                          valid_in,
   output logic                          ready_out,
   input  logic                          cts_n_in,
   output logic                          tx_out,
   output logic                          busy_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(BAUD_COUNT + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_COUNT - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ready_q, ready_d;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic          stop_q, stop_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic          tx_q, tx_d;
   logic          busy_q, busy_d;

   logic push, pop, launch, baud_wrap, start_ok;

   assign push      = valid_in && ready_q;
   assign baud_wrap = (baud_q == BAUD_LAST);
   assign start_ok  = (count_q != '0) && !cts_n_in;

   // Frame sequencing; a new frame may launch from IDLE or straight out of the last stop bit.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      launch  = 1'b0;
      if (state_q != IDLE) begin
         baud_d = baud_wrap ? '0 : baud_q + 1'b1;
      end
      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            launch = start_ok;
         end
         START: begin
            if (baud_wrap) begin
               state_d = DATA;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (baud_wrap) begin
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par_q;
`else
                  state_d = STOP;
                  stop_d  = 1'b0;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (baud_wrap) begin
               state_d = STOP;
               stop_d  = 1'b0;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (baud_wrap) begin
               if (stop_q == STOP_LAST) begin
                  if (start_ok) begin
                     launch = 1'b1;
                  end else begin
                     state_d = IDLE;
                     tx_d    = 1'b1;
                     busy_d  = 1'b0;
                  end
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (launch) begin
         state_d = START;
         shift_d = mem[rd_ptr_q];
         par_d   = ^mem[rd_ptr_q];
         baud_d  = '0;
         tx_d    = 1'b0;
         busy_d  = 1'b1;
      end
   end

   // A pop only occurs on launch, which already requires a non-empty FIFO.
   always_comb begin
      pop      = launch;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      ready_d  = (count_d != CW'(FIFO_DEPTH));
   end

   always_ff @(posedge clk_in) begin
      if (push) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= 3'd0;
         stop_q   <= 1'b0;
         shift_q  <= 8'h00;
         par_q    <= 1'b0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         shift_q  <= shift_d;
         par_q    <= par_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
      end
   end

   assign tx_out         = tx_q;
   assign busy_out       = busy_q;
   assign ready_out      = ready_q;
   assign fifo_count_out = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with BAUD_COUNT=4, FIFO_DEPTH=4, STOP_BITS=1.
module tb_uart_tx_fifo;

   localparam int BAUD  = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * BAUD;

   logic       clk_in   = 1'b0;
   logic       rst_in   = 1'b1;
   logic [7:0] data_in  = 8'h00;
   logic       valid_in = 1'b0;
   logic       cts_n_in = 1'b1;
   logic       ready_out, tx_out, busy_out;
   logic [$clog2(DEPTH):0] fifo_count_out;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;
   } vec_t;

   vec_t        vecs [6];
   logic [7:0]  q_bytes [5];
   logic [10:0] q_frames [4];

   uart_tx_fifo #(.BAUD_COUNT(BAUD), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .data_in(data_in),
      .valid_in(valid_in),
      .ready_out(ready_out),
      .cts_n_in(cts_n_in),
      .tx_out(tx_out),
      .busy_out(busy_out),
      .fifo_count_out(fifo_count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] d, input logic v, input logic c);
      data_in  = d;
      valid_in = v;
      cts_n_in = c;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic pushByte(input logic [7:0] d, input logic c);
      applyStimulus(d, 1'b1, c);
      tick();
      applyStimulus(d, 1'b0, c);
   endtask

   // Called with the first busy cycle already sampled; samples each bit mid-slot.
   task automatic captureFrame(output logic [10:0] bits, output int busy_len);
      int i;
      bits = '0;
      i = 0;
      while (busy_out && i < 400) begin
         if ((i % BAUD) == BAUD / 2 && (i / BAUD) < 11) bits[i / BAUD] = tx_out;
         i++;
         tick();
      end
      busy_len = i;
   endtask

   initial begin
      logic [10:0] bits;
      logic [10:0] got [4];
      int          blen;
      int          gaps;
      int          i;

`ifdef UART_TX_PARITY_EN
      vecs[0] = '{8'h55, 11'h4AA};
      vecs[1] = '{8'hA3, 11'h546};
      vecs[2] = '{8'h00, 11'h400};
      vecs[3] = '{8'hFF, 11'h5FE};
      vecs[4] = '{8'h07, 11'h60E};
      vecs[5] = '{8'h03, 11'h406};
      q_frames[0] = 11'h422;
      q_frames[1] = 11'h444;
      q_frames[2] = 11'h466;
      q_frames[3] = 11'h488;
`else
      vecs[0] = '{8'h55, 11'h2AA};
      vecs[1] = '{8'hA3, 11'h346};
      vecs[2] = '{8'h00, 11'h200};
      vecs[3] = '{8'hFF, 11'h3FE};
      vecs[4] = '{8'h07, 11'h20E};
      vecs[5] = '{8'h03, 11'h206};
      q_frames[0] = 11'h222;
      q_frames[1] = 11'h244;
      q_frames[2] = 11'h266;
      q_frames[3] = 11'h288;
`endif
      q_bytes[0] = 8'h11;
      q_bytes[1] = 8'h22;
      q_bytes[2] = 8'h33;
      q_bytes[3] = 8'h44;
      q_bytes[4] = 8'h99;

      // Reset state and release
      repeat (3) tick();
      checkOutput("reset_tx", 32'(tx_out), 32'd1);
      checkOutput("reset_busy", 32'(busy_out), 32'd0);
      checkOutput("reset_ready", 32'(ready_out), 32'd0);
      checkOutput("reset_count", 32'(fifo_count_out), 32'd0);
      rst_in = 1'b0;
      #1;
      checkOutput("ready_before_edge", 32'(ready_out), 32'd0);
      tick();
      checkOutput("ready_after_release", 32'(ready_out), 32'd1);

      // Single frames from the table
      for (int v = 0; v < 6; v++) begin
         pushByte(vecs[v].data, 1'b0);
         checkOutput($sformatf("v%0d_count_after_push", v), 32'(fifo_count_out), 32'd1);
         checkOutput($sformatf("v%0d_tx_idle", v), 32'(tx_out), 32'd1);
         tick();
         checkOutput($sformatf("v%0d_start_low", v), 32'(tx_out), 32'd0);
         captureFrame(bits, blen);
         checkOutput($sformatf("v%0d_frame", v), 32'(bits), 32'(vecs[v].frame));
         checkOutput($sformatf("v%0d_busy_len", v), 32'(blen), 32'(FRAME_CYC));
      end

      // CTS held off: fill the FIFO, fifth write refused
      for (int k = 0; k < 5; k++) begin
         applyStimulus(q_bytes[k], 1'b1, 1'b1);
         tick();
         if (k == 3) begin
            checkOutput("full_ready", 32'(ready_out), 32'd0);
            checkOutput("full_count", 32'(fifo_count_out), 32'd4);
         end
      end
      applyStimulus(8'h00, 1'b0, 1'b1);
      checkOutput("refused_count", 32'(fifo_count_out), 32'd4);
      repeat (20) tick();
      checkOutput("held_tx", 32'(tx_out), 32'd1);
      checkOutput("held_busy", 32'(busy_out), 32'd0);
      checkOutput("held_count", 32'(fifo_count_out), 32'd4);

      // Release CTS: four back-to-back frames
      applyStimulus(8'h00, 1'b0, 1'b0);
      tick();
      gaps = 0;
      for (int k = 0; k < 4; k++) got[k] = '0;
      for (int n = 0; n < 4 * FRAME_CYC; n++) begin
         if ((n % FRAME_CYC) == 0)
            checkOutput($sformatf("b2b_count_f%0d", n / FRAME_CYC), 32'(fifo_count_out), 32'(3 - n / FRAME_CYC));
         if (!busy_out) gaps++;
         if (((n % FRAME_CYC) % BAUD) == BAUD / 2)
            got[n / FRAME_CYC][(n % FRAME_CYC) / BAUD] = tx_out;
         tick();
      end
      checkOutput("b2b_gaps", 32'(gaps), 32'd0);
      checkOutput("b2b_done_busy", 32'(busy_out), 32'd0);
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("b2b_frame%0d", k), 32'(got[k]), 32'(q_frames[k]));

      // CTS deasserted mid-frame: frame completes, next byte held
      pushByte(8'hC5, 1'b0);
      pushByte(8'h3A, 1'b0);
      checkOutput("cts_mid_count", 32'(fifo_count_out), 32'd1);
      checkOutput("cts_mid_busy", 32'(busy_out), 32'd1);
      i = 0;
      while (busy_out && i < 400) begin
         if (i == 10) cts_n_in = 1'b1;
         i++;
         tick();
      end
      checkOutput("cts_mid_len", 32'(i), 32'(FRAME_CYC));
      repeat (20) tick();
      checkOutput("cts_hold_busy", 32'(busy_out), 32'd0);
      checkOutput("cts_hold_tx", 32'(tx_out), 32'd1);
      checkOutput("cts_hold_count", 32'(fifo_count_out), 32'd1);
      applyStimulus(8'h00, 1'b0, 1'b0);
      tick();
      checkOutput("cts_resume_tx", 32'(tx_out), 32'd0);
      checkOutput("cts_resume_count", 32'(fifo_count_out), 32'd0);
      captureFrame(bits, blen);
`ifdef UART_TX_PARITY_EN
      checkOutput("cts_resume_frame", 32'(bits), 32'h474);
`else
      checkOutput("cts_resume_frame", 32'(bits), 32'h274);
`endif

      // Reset mid-frame with two bytes queued
      pushByte(8'h81, 1'b0);
      pushByte(8'h42, 1'b0);
      pushByte(8'h24, 1'b0);
      checkOutput("rstmid_count", 32'(fifo_count_out), 32'd2);
      repeat (16) tick();
      checkOutput("rstmid_busy_before", 32'(busy_out), 32'd1);
      rst_in = 1'b1;
      #1;
      checkOutput("rstmid_tx", 32'(tx_out), 32'd1);
      checkOutput("rstmid_busy", 32'(busy_out), 32'd0);
      checkOutput("rstmid_count0", 32'(fifo_count_out), 32'd0);
      checkOutput("rstmid_ready", 32'(ready_out), 32'd0);
      repeat (2) tick();
      rst_in = 1'b0;
      tick();
      checkOutput("rstmid_ready_after", 32'(ready_out), 32'd1);
      gaps = 0;
      for (int n = 0; n < 60; n++) begin
         if (!tx_out || busy_out || fifo_count_out != 0) gaps++;
         tick();
      end
      checkOutput("rstmid_quiet", 32'(gaps), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
